// File: rtl/clk_ctrl_if.sv
// Handshake bundle between clk_ctrl and its debug/control side.
// Optional CLK_CTRL_CYCLE_CNT_EN adds the 32-bit ce_count output.
interface clk_ctrl_if #(
  parameter int unsigned DIV_WIDTH = 8
);
  logic [DIV_WIDTH-1:0] div;
  logic                 halt_req;
  logic                 step_req;
  logic                 core_rst_n;
  logic                 ce;
  logic                 halted;
`ifdef CLK_CTRL_CYCLE_CNT_EN
  logic [31:0]          ce_count;

  modport master (output div, halt_req, step_req,
                  input  core_rst_n, ce, halted, ce_count);
  modport slave  (input  div, halt_req, step_req,
                  output core_rst_n, ce, halted, ce_count);
`else
  modport master (output div, halt_req, step_req,
                  input  core_rst_n, ce, halted);
  modport slave  (input  div, halt_req, step_req,
                  output core_rst_n, ce, halted);
`endif
endinterface

// File: rtl/clk_ctrl.sv
// Core reset sequencer and clock-enable generator with halt/single-step.
// Optional feature macro: CLK_CTRL_CYCLE_CNT_EN (adds bus.ce_count).
module clk_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned DIV_WIDTH   = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  clk_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RESET_HOLD, RUN, HALTED, STEP} state_t;

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [HOLD_W-1:0]      hcnt_q, hcnt_d;
  logic [DIV_WIDTH-1:0]   dcnt_q, dcnt_d;
  logic                   step_prev_q, step_prev_d;
  logic                   core_rst_n_q, core_rst_n_d;
  logic                   ce_q, ce_d;
  logic                   halted_q, halted_d;
  logic                   rst_s;
  logic                   step_rise;
`ifdef CLK_CTRL_CYCLE_CNT_EN
  logic [31:0]            cnt_q, cnt_d;
`endif

  assign rst_s     = sync_q[SYNC_STAGES-1];
  assign step_rise = bus.step_req & ~step_prev_q;

  // Next-state logic for the synchronizer, hold sequencer, divider and debug FSM.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], 1'b1};
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    dcnt_d       = dcnt_q;
    step_prev_d  = bus.step_req;
    core_rst_n_d = core_rst_n_q;
    ce_d         = 1'b0;
    halted_d     = halted_q;
    case (state_q)
      RESET_HOLD: begin
        core_rst_n_d = 1'b0;
        halted_d     = 1'b0;
        dcnt_d       = '0;
        if (rst_s) begin
          if (hcnt_q == HOLD_LAST) begin
            state_d      = RUN;
            core_rst_n_d = 1'b1;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        // Halt takes priority over a divider match in the same cycle.
        if (bus.halt_req) begin
          state_d  = HALTED;
          halted_d = 1'b1;
          dcnt_d   = '0;
        end else if (dcnt_q >= bus.div) begin
          ce_d   = 1'b1;
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      HALTED: begin
        // Release beats a coincident step edge.
        if (!bus.halt_req) begin
          state_d  = RUN;
          halted_d = 1'b0;
          dcnt_d   = '0;
        end else if (step_rise) begin
          state_d = STEP;
          ce_d    = 1'b1;
        end
      end
      STEP: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RESET_HOLD;
      end
    endcase
  end

`ifdef CLK_CTRL_CYCLE_CNT_EN
  // Pulse counter, cleared for the whole reset hold and counting alongside ce.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == RESET_HOLD) cnt_d = '0;
    else if (ce_d)             cnt_d = cnt_q + 32'd1;
  end
`endif

  // All state registers share the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      state_q      <= RESET_HOLD;
      hcnt_q       <= '0;
      dcnt_q       <= '0;
      step_prev_q  <= 1'b0;
      core_rst_n_q <= 1'b0;
      ce_q         <= 1'b0;
      halted_q     <= 1'b0;
`ifdef CLK_CTRL_CYCLE_CNT_EN
      cnt_q        <= '0;
`endif
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      dcnt_q       <= dcnt_d;
      step_prev_q  <= step_prev_d;
      core_rst_n_q <= core_rst_n_d;
      ce_q         <= ce_d;
      halted_q     <= halted_d;
`ifdef CLK_CTRL_CYCLE_CNT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign bus.core_rst_n = core_rst_n_q;
  assign bus.ce         = ce_q;
  assign bus.halted     = halted_q;
`ifdef CLK_CTRL_CYCLE_CNT_EN
  assign bus.ce_count   = cnt_q;
`endif

endmodule
